// File: rtl/multi_timer.sv
// multi_timer: parametrised multi-channel down-counting timer.
//
// Each channel counts a run-time length L in one-shot or periodic mode. It
// can be restarted or cancelled at any edge. It reports busy status and a
// registered one-cycle done pulse at expiry.
//
// Optional feature macro: MULTI_TIMER_PRESCALE_EN. When it is defined, a
// shared prescaler slows every channel's count edges to one per
// (prescale+1) clock cycles.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   [NUM_CH]        per-channel start/restart request
//   stop      in   [NUM_CH]        per-channel cancel (wins over start)
//   periodic  in   [NUM_CH]        1 = reload at expiry, 0 = one-shot
//   load_val  in   [NUM_CH*WIDTH]  count length L, channel i at [i*WIDTH +: WIDTH]
//   prescale  in   [PRESCALE_WIDTH] tick divider P (MULTI_TIMER_PRESCALE_EN only)
//   busy      out  [NUM_CH]        channel is running
//   done      out  [NUM_CH]        one-cycle expiry pulse
module multi_timer #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*WIDTH-1:0]   load_val,
`ifdef MULTI_TIMER_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] prescale,
`endif
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q [NUM_CH];
  logic [WIDTH-1:0] cnt_q   [NUM_CH];
  logic [WIDTH-1:0] ld      [NUM_CH];
  logic [NUM_CH-1:0] busy_q, done_q;
  logic [NUM_CH-1:0] cnt_en;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ld[i] = load_val[i*WIDTH +: WIDTH];
    end
  end

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] pre_q;
  logic [NUM_CH-1:0]         align_q;
  logic                      tick;

  // The prescaler counts down from P and reloads on reaching zero. A new
  // prescale value therefore only lands at the next wrap.
  assign tick = (pre_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= prescale;
    end else begin
      pre_q <= pre_q - PRESCALE_WIDTH'(1);
    end
  end

  // A channel latched between ticks spends its first tick only aligning to
  // the prescaler grid. Each counted unit then spans a full P+1 cycles, so
  // expiry falls L*(P+1) .. L*(P+1)+P cycles after the latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      align_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (stop[i]) begin
          align_q[i] <= 1'b0;
        end else if (start[i] && ld[i] != '0) begin
          align_q[i] <= ~tick;
        end else if (tick) begin
          align_q[i] <= 1'b0;
        end
      end
    end
  end

  assign cnt_en = {NUM_CH{tick}} & ~align_q;
`else
  // PRESCALE_WIDTH has no effect in this build.
  logic [PRESCALE_WIDTH-1:0] unused_prescale;
  assign unused_prescale = '0;
  assign cnt_en          = '1;
`endif

  // Per-channel FSM. Within one edge the terminal handling comes first and a
  // restart follows it. A restart that lands on the terminal edge therefore
  // keeps the done pulse and overrides the reload or IDLE decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        done_q[i] <= 1'b0;
        if (stop[i]) begin
          state_q[i] <= IDLE;
          busy_q[i]  <= 1'b0;
        end else begin
          if (state_q[i] == RUN && cnt_en[i]) begin
            if (cnt_q[i] == WIDTH'(1)) begin
              done_q[i] <= 1'b1;
              if (periodic[i] && ld[i] != '0) begin
                cnt_q[i] <= ld[i];
              end else begin
                state_q[i] <= IDLE;
                busy_q[i]  <= 1'b0;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] - WIDTH'(1);
            end
          end
          if (start[i] && ld[i] != '0) begin
            state_q[i] <= RUN;
            busy_q[i]  <= 1'b1;
            cnt_q[i]   <= ld[i];
          end
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel down-counting timer. It replaces single-channel fixed-count timers wherever several delays or periodic ticks are needed from one clock domain. Each channel takes its count length at run time, runs in one-shot or periodic mode, can be cancelled, and reports busy status and a one-cycle done pulse. An optional shared prescaler stretches every channel's time base.

## Interface
Parameters:
- `NUM_CH`, default 2: number of independent channels, ≥1.
- `WIDTH`, default 16: counter width per channel, ≥2.
- `PRESCALE_WIDTH`, default 8: prescaler width. Used only with `MULTI_TIMER_PRESCALE_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  NUM_CH  per-channel start/restart request, sampled every edge.
- `stop`  in  NUM_CH  per-channel cancel, sampled every edge.
- `periodic`  in  NUM_CH  per-channel mode: 1 = periodic, 0 = one-shot. Sampled at each terminal edge.
- `load_val`  in  NUM_CH*WIDTH  count length L; channel i uses bits [i*WIDTH +: WIDTH].
- `prescale`  in  PRESCALE_WIDTH  tick divider P. Port exists only with `MULTI_TIMER_PRESCALE_EN`.
- `busy`  out  NUM_CH  channel is in RUN.
- `done`  out  NUM_CH  one-cycle pulse at expiry, registered.

## Operation
- Each channel has two states, IDLE and RUN, and a WIDTH-bit counter `cnt`.
- IDLE → RUN: `start`=1, `stop`=0 and L≠0. The counter latches `cnt`<=L at that edge (E0). If L=0, `start` is ignored and the channel stays IDLE.
- In RUN:
  - If `cnt`≠1, the counter decrements by 1 per count edge.
  - When `cnt`==1 (the terminal edge), `done`<=1.
  - At the terminal edge with `periodic`=1: reload `cnt`<=current L and stay in RUN. If that L is 0, go to IDLE instead.
  - At the terminal edge with `periodic`=0: go to IDLE.
- Restart: `start` in RUN relatches `cnt`<=L at that edge. If the same edge is terminal, `done` still pulses and the restart value is used.
- Cancel: `stop` forces IDLE and suppresses `done` at that edge, terminal or not. `stop` wins over a simultaneous `start`.
- Channels are fully independent. Same-edge events on different channels do not interact.
- Counter arithmetic is unsigned WIDTH-bit. Wrap-around cannot occur because the counter never decrements from 0 or 1. Maximum L is 2^WIDTH−1.

## Timing
- Reset: on an edge with `rst`=1, every channel goes to IDLE, `cnt`=0, `busy`=0, `done`=0, and the prescaler is cleared. Reset mid-count aborts with no `done` pulse.
- `busy` rises in the cycle after E0 and falls in the cycle after the terminal edge (one-shot) or the stop edge.
- Latency without prescaler: start sampled at E0 gives `done` high for exactly the one cycle following edge E0+L.
- Periodic mode: `done` pulses every L cycles, i.e. at E0+L, E0+2L, and so on. The period has no gap cycle.
- L=1: `done` pulses after E0+1. In periodic mode `done` stays high continuously.
- `done` and `busy` are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `MULTI_TIMER_PRESCALE_EN`.
- Defined:
  - A shared free-running prescaler produces a `tick` every P+1 cycles; P=0 means a tick every cycle.
  - The start latch, restart and `stop` act on any edge.
  - Decrement and terminal detection occur only on edges where `tick`=1. `done` follows the terminal tick edge by one cycle.
  - E0 to `done` is between L·(P+1) and L·(P+1)+P cycles. This is first-tick jitter.
  - A change to `prescale` takes effect on the next prescaler wrap.
- Undefined: the `prescale` port and the prescaler logic are absent, and every edge is a count edge.

## Test plan
- Reset, then one-shot: ch0 L=101 and ch1 L=900, both started on the same edge. Required: `done[0]` 101 cycles after start and `done[1]` 900 cycles after, each one cycle wide; `busy` high exactly L cycles. Repeat twice with identical results.
- Periodic: ch0 L=5 `periodic`=1, run 30 cycles. Required: `done` at +5, +10, +15, +20, +25, +30. Set `periodic`=0 before +35; required: last pulse at +35, then `busy`=0.
- Restart and stop: L=50, `start` again at +20; required: `done` at +70 only. Second run: `stop` at +30; required: no `done`, `busy`=0 after +30. `stop`+`start` on the same edge: required: IDLE.
- Boundaries: L=0 start → stays IDLE. L=1 → `done` at +1. Stop on the terminal edge → no `done`. Restart on the terminal edge → `done` pulses and the next `done` is at terminal+L.
- Mid-count reset: L=900, assert `rst` at +400 for one cycle. Required: all outputs 0 from the next cycle and no `done` for 1000 further cycles.
- With `MULTI_TIMER_PRESCALE_EN`, P=3, L=10: required: `done` 40–43 cycles after start. Periodic spacing is exactly 40 cycles.
